// File: rtl/up_cfg_sequencer.sv
// up_cfg_sequencer: autonomous up_* bus initiator that walks a command
// table (WRITE / POLL / DELAY / END) held in an external ROM/RAM.
// Optional feature: define UP_CFG_SEQ_WRITE_VERIFY_EN to read back every
// WRITE (non-zero mask) and abort with code 5 on a masked mismatch.
module up_cfg_sequencer #(
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int ACK_TIMEOUT    = 64,
    parameter int POLL_RETRIES   = 1024,
    parameter int POLL_GAP       = 16
) (
    input  logic                      up_clk,
    input  logic                      up_rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [2:0]                error_code,
    output logic [CMD_ADDR_WIDTH-1:0] error_index,
    output logic [CMD_ADDR_WIDTH-1:0] cmd_raddr,
    input  logic [95:0]               cmd_rdata,
    output logic                      up_wreq,
    output logic [13:0]               up_waddr,
    output logic [31:0]               up_wdata,
    input  logic                      up_wack,
    output logic                      up_rreq,
    output logic [13:0]               up_raddr,
    input  logic [31:0]               up_rdata,
    input  logic                      up_rack
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WR_REQ, S_WR_WAIT, S_RD_REQ,
        S_RD_WAIT, S_CHECK, S_GAP, S_DELAY, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [CMD_ADDR_WIDTH-1:0] IDX_LAST = '1;
    localparam logic [CMD_ADDR_WIDTH-1:0] IDX_ONE  = CMD_ADDR_WIDTH'(1);

    state_t state, state_nxt;

    logic [CMD_ADDR_WIDTH-1:0] index;
    logic [13:0] cmd_addr;
    logic [31:0] cmd_mask;
    logic [31:0] cmd_data;
    logic [31:0] rd_data;
    logic [31:0] cnt;       // shared: ack timeout, poll gap, delay
    logic [31:0] poll_cnt;  // reads issued for the current command
    logic        verify;    // current read is a write readback, not a POLL

    // strobes from the FSM to the datapath
    logic       clr, adv, ld_cmd, cap_rd, vfy_set, cmd_done;
    logic       cnt_ld1, cnt_clr, cnt_inc, poll_clr, poll_inc;
    logic       err_set;
    logic [2:0] err_code_nxt;

    // reserved entry field carries no meaning
    logic unused_rsvd;
    assign unused_rsvd = ^cmd_rdata[79:64];

    // state register
    always_ff @(posedge up_clk) begin
        if (up_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state and datapath strobes
    always_comb begin
        state_nxt    = state;
        clr          = 1'b0;
        adv          = 1'b0;
        ld_cmd       = 1'b0;
        cap_rd       = 1'b0;
        vfy_set      = 1'b0;
        cmd_done     = 1'b0;
        cnt_ld1      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        poll_clr     = 1'b0;
        poll_inc     = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = 3'd0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                ld_cmd   = 1'b1;
                cnt_clr  = 1'b1;
                poll_clr = 1'b1;
                case (cmd_rdata[95:94])
                    OP_WRITE: state_nxt = S_WR_REQ;
                    OP_POLL:  state_nxt = S_RD_REQ;
                    OP_DELAY: state_nxt = S_DELAY;
                    default:  state_nxt = S_DONE;
                endcase
            end
            S_WR_REQ: begin
                cnt_ld1   = 1'b1;  // the req cycle counts as the first timeout cycle
                state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (up_wack) begin
`ifdef UP_CFG_SEQ_WRITE_VERIFY_EN
                    if (cmd_mask != '0) begin
                        vfy_set   = 1'b1;
                        state_nxt = S_RD_REQ;
                    end else begin
                        cmd_done = 1'b1;
                    end
`else
                    cmd_done = 1'b1;
`endif
                end else if (cnt == ACK_TIMEOUT - 1) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'd1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RD_REQ: begin
                cnt_ld1   = 1'b1;
                poll_inc  = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (up_rack) begin
                    cap_rd    = 1'b1;
                    state_nxt = S_CHECK;
                end else if (cnt == ACK_TIMEOUT - 1) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'd2;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_CHECK: begin
                if ((rd_data & cmd_mask) == (cmd_data & cmd_mask)) begin
                    cmd_done = 1'b1;
                end else if (verify) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'd5;
                end else if (poll_cnt == POLL_RETRIES) begin
                    err_set      = 1'b1;
                    err_code_nxt = 3'd3;
                end else if (POLL_GAP == 0) begin
                    state_nxt = S_RD_REQ;
                end else begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == POLL_GAP - 1) state_nxt = S_RD_REQ;
                else                     cnt_inc   = 1'b1;
            end
            S_DELAY: begin
                // a zero count still spends this one cycle
                if (cnt + 32'd1 >= {8'd0, cmd_data[23:0]}) cmd_done = 1'b1;
                else                                       cnt_inc  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        // retire a command: step the index, refusing to run off the table
        if (cmd_done) begin
            if (index == IDX_LAST) begin
                err_set      = 1'b1;
                err_code_nxt = 3'd4;
            end else begin
                adv       = 1'b1;
                state_nxt = S_FETCH;
            end
        end
        if (err_set) state_nxt = S_ERR;
    end

    // datapath: table index, latched entry, counters and error record
    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            index       <= '0;
            cmd_addr    <= '0;
            cmd_mask    <= '0;
            cmd_data    <= '0;
            rd_data     <= '0;
            cnt         <= '0;
            poll_cnt    <= '0;
            verify      <= 1'b0;
            error_code  <= '0;
            error_index <= '0;
        end else begin
            if (clr) begin
                index      <= '0;
                error_code <= '0;
            end
            if (adv) index <= index + IDX_ONE;
            if (ld_cmd) begin
                cmd_addr <= cmd_rdata[93:80];
                cmd_mask <= cmd_rdata[63:32];
                cmd_data <= cmd_rdata[31:0];
                verify   <= 1'b0;
            end
            if (vfy_set) verify  <= 1'b1;
            if (cap_rd)  rd_data <= up_rdata;
            if (cnt_ld1)      cnt <= 32'd1;
            else if (cnt_clr) cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 32'd1;
            if (poll_clr)      poll_cnt <= '0;
            else if (poll_inc) poll_cnt <= poll_cnt + 32'd1;
            if (err_set) begin
                error_code  <= err_code_nxt;
                error_index <= index;
            end
        end
    end

    assign busy      = !(state inside {S_IDLE, S_DONE, S_ERR});
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cmd_raddr = index;
    assign up_wreq   = (state == S_WR_REQ);
    assign up_rreq   = (state == S_RD_REQ);
    assign up_waddr  = cmd_addr;
    assign up_raddr  = cmd_addr;
    assign up_wdata  = cmd_data;

endmodule

// File: tb/tb_up_cfg_sequencer.sv
// Bench for up_cfg_sequencer: table ROM, scripted up_* responder, a
// table-walking expectation model and a per-cycle compare process.
module tb_up_cfg_sequencer;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int ATO   = 8;
    localparam int RETRY = 4;
    localparam int GAP   = 3;

    logic          up_clk = 1'b0;
    logic          up_rst, start;
    logic          busy, done, error;
    logic [2:0]    error_code;
    logic [AW-1:0] error_index, cmd_raddr;
    logic [95:0]   cmd_rdata;
    logic          up_wreq, up_wack, up_rreq, up_rack;
    logic [13:0]   up_waddr, up_raddr;
    logic [31:0]   up_wdata, up_rdata;

    up_cfg_sequencer #(
        .CMD_ADDR_WIDTH(AW), .ACK_TIMEOUT(ATO),
        .POLL_RETRIES(RETRY), .POLL_GAP(GAP)
    ) dut (
        .up_clk(up_clk), .up_rst(up_rst), .start(start),
        .busy(busy), .done(done), .error(error),
        .error_code(error_code), .error_index(error_index),
        .cmd_raddr(cmd_raddr), .cmd_rdata(cmd_rdata),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
    );

    always #5 up_clk = ~up_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] ent(input logic [1:0] op, input logic [13:0] a,
                                        input logic [31:0] m, input logic [31:0] d);
        return {op, a, 16'hBEEF, m, d};
    endfunction

    // table memory: one-cycle read latency
    logic [95:0] tbl [DEPTH];
    always @(posedge up_clk) cmd_rdata <= tbl[cmd_raddr];

    // responder: ack after wlat/rlat cycles (0 = never), read data from script
    int          wlat, rlat, rs_i, w_cd, r_cd;
    logic [31:0] rd_script[$];
    bit          both_ack, inject;
    initial begin
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0;
        w_cd = -1; r_cd = -1; rs_i = 0; inject = 1'b0;
        forever begin
            @(posedge up_clk); #1;
            up_wack = 1'b0;
            up_rack = 1'b0;
            if (w_cd > 0) begin
                w_cd--;
                if (w_cd == 0) up_wack = 1'b1;
            end
            if (r_cd > 0) begin
                r_cd--;
                if (r_cd == 0) begin
                    up_rack  = 1'b1;
                    up_rdata = (rs_i < rd_script.size()) ? rd_script[rs_i] : 32'd0;
                    rs_i++;
                    if (both_ack) up_wack = 1'b1;
                end
            end
            if (inject) begin
                up_rack  = 1'b1;
                up_rdata = 32'hFFFF_FFFF;
                inject   = 1'b0;
            end
            if (up_wreq && wlat > 0) w_cd = wlat;
            if (up_rreq && rlat > 0) r_cd = rlat;
        end
    end

    // expectation model: walk the table using the responder script
    typedef struct {
        bit          is_w;
        logic [13:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];
    txn_t e_pop;
    bit   exp_done;
    int   exp_code, exp_idx, exp_nw, exp_nr;

    function automatic bit ack_ok(input int lat);
        return (lat >= 1) && (lat <= ATO - 1);
    endfunction

    task automatic build_model();
        int idx, si, fin, hit;
        logic [95:0] e;
        logic [31:0] v, m, d;
        exp_q.delete();
        exp_done = 0; exp_code = 0; exp_idx = 0; exp_nw = 0; exp_nr = 0;
        idx = 0; si = 0; fin = 0;
        while (fin == 0) begin
            e = tbl[idx];
            m = e[63:32];
            d = e[31:0];
            if (e[95:94] == 2'b00) begin
                exp_q.push_back('{1'b1, e[93:80], d}); exp_nw++;
                if (!ack_ok(wlat)) begin exp_code = 1; fin = 1; end
`ifdef UP_CFG_SEQ_WRITE_VERIFY_EN
                else if (m != 0) begin
                    exp_q.push_back('{1'b0, e[93:80], 32'd0}); exp_nr++;
                    v = (si < rd_script.size()) ? rd_script[si] : 32'd0; si++;
                    if (!ack_ok(rlat)) begin exp_code = 2; fin = 1; end
                    else if ((v & m) != (d & m)) begin exp_code = 5; fin = 1; end
                end
`endif
            end else if (e[95:94] == 2'b01) begin
                hit = 0;
                for (int n = 0; n < RETRY && hit == 0 && fin == 0; n++) begin
                    exp_q.push_back('{1'b0, e[93:80], 32'd0}); exp_nr++;
                    v = (si < rd_script.size()) ? rd_script[si] : 32'd0; si++;
                    if (!ack_ok(rlat)) begin exp_code = 2; fin = 1; end
                    else if ((v & m) == (d & m)) hit = 1;
                end
                if (hit == 0 && fin == 0) begin exp_code = 3; fin = 1; end
            end else if (e[95:94] == 2'b11) begin
                exp_done = 1; fin = 1;
            end
            if (fin == 0) begin
                if (idx == DEPTH - 1) begin exp_code = 4; fin = 1; end
                else idx++;
            end
        end
        exp_idx = idx;
    endtask

    // per-cycle compare against the model and the bus rules
    int cyc = 0, busy_cyc = -1, wreq_cyc = -1, err_cyc = -1, done_cyc = -1;
    int nw = 0, nr = 0, last_rreq = -1, out_k = 0;
    logic [13:0] out_a;
    logic [31:0] out_d;
    bit pb = 0, pd = 0, pe = 0;
    always @(negedge up_clk) begin
        cyc++;
        if (!busy) out_k = 0;
        chk("status_exclusive", 96'($countones({busy, done, error}) > 1), 96'd0);
        chk("code_without_error", 96'(!error && error_code != 3'd0), 96'd0);
        chk("req_rules", 96'(((up_wreq || up_rreq) && !busy) || (up_wreq && up_rreq)), 96'd0);
        if (up_wack && out_k == 1) begin
            chk("waddr_held", 96'(up_waddr), 96'(out_a));
            chk("wdata_held", 96'(up_wdata), 96'(out_d));
            out_k = 0;
        end
        if (up_rack && out_k == 2) begin
            chk("raddr_held", 96'(up_raddr), 96'(out_a));
            out_k = 0;
        end
        if (up_wreq || up_rreq) begin
            chk("one_outstanding", 96'(out_k), 96'd0);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_req: got a request at cycle %0d, required none", cyc);
            end else begin
                e_pop = exp_q.pop_front();
                chk("req_kind", 96'(up_wreq), 96'(e_pop.is_w));
                chk("req_addr", 96'(up_wreq ? up_waddr : up_raddr), 96'(e_pop.addr));
                if (e_pop.is_w) chk("req_wdata", 96'(up_wdata), 96'(e_pop.data));
            end
            out_k = up_wreq ? 1 : 2;
            out_a = up_wreq ? up_waddr : up_raddr;
            out_d = up_wdata;
            if (up_wreq) begin
                nw++; wreq_cyc = cyc; last_rreq = -1;
            end else begin
                if (last_rreq >= 0) chk("poll_gap", 96'((cyc - last_rreq - 1) >= GAP), 96'd1);
                last_rreq = cyc; nr++;
            end
        end
        if (busy && !pb) begin busy_cyc = cyc; last_rreq = -1; end
        if (error && !pe) err_cyc = cyc;
        if (done && !pd) done_cyc = cyc;
        pb = busy; pd = done; pe = error;
    end

    task automatic set_tbl(input logic [95:0] e0, input logic [95:0] e1,
                           input logic [95:0] e2, input logic [95:0] e3);
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, 96'({busy, done, error, error_code, error_index, cmd_raddr, up_wreq,
                     up_waddr, up_wdata, up_rreq, up_raddr}), 96'd0);
    endtask

    task automatic run_seq(input string nm, input int budget, input bit restart);
        int n;
        build_model();
        nw = 0; nr = 0; w_cd = -1; r_cd = -1; rs_i = 0;
        wreq_cyc = -1; err_cyc = -1; done_cyc = -1;
        @(posedge up_clk); #1 start = 1'b1;
        @(posedge up_clk); #1 start = 1'b0;
        chk({nm, "_busy_on_start"}, 96'(busy), 96'd1);
        n = 0;
        while (busy && n < budget) begin
            start = restart && (n == 4);
            @(posedge up_clk); #1;
            n++;
        end
        start = 1'b0;
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s_finish: busy still 1 after %0d cycles, required 0", nm, budget);
        end
        repeat (ATO + 2) @(posedge up_clk);
        #1;
        chk({nm, "_done"}, 96'(done), 96'(exp_done));
        chk({nm, "_error"}, 96'(error), 96'(exp_code != 0));
        chk({nm, "_code"}, 96'(error_code), 96'(exp_code));
        if (exp_code != 0) chk({nm, "_index"}, 96'(error_index), 96'(exp_idx));
        chk({nm, "_nwrites"}, 96'(nw), 96'(exp_nw));
        chk({nm, "_nreads"}, 96'(nr), 96'(exp_nr));
        chk({nm, "_queue_empty"}, 96'(exp_q.size()), 96'd0);
    endtask

    localparam logic [1:0] W = 2'b00, P = 2'b01, D = 2'b10, E = 2'b11;

    initial begin
        up_rst = 1'b1; start = 1'b0;
        wlat = 1; rlat = 1; both_ack = 1'b0;
        set_tbl(ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        repeat (3) @(posedge up_clk);
        #1;
        check_all_zero("reset_outputs");
        up_rst = 1'b0;

        // single write then END
        set_tbl(ent(W, 14'h0040, 0, 32'h3), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        wlat = 2; rd_script = {};
        run_seq("write", 100, 1'b0);
        chk("write_model", 96'({exp_done, 8'(exp_nw), 8'(exp_nr)}), 96'({1'b1, 8'd1, 8'd0}));
        chk("write_req_offset", 96'(wreq_cyc - busy_cyc), 96'd2);
        chk("write_done_latency", 96'(done_cyc - wreq_cyc), 96'd5);

        // poll: three misses then a hit, extra wack alongside rack, start while busy
        set_tbl(ent(P, 14'h0017, 32'h1, 32'h1), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        rlat = 1; both_ack = 1'b1; rd_script = {32'h0, 32'h0, 32'h0, 32'h1};
        run_seq("poll", 200, 1'b1);
        chk("poll_model_reads", 96'(exp_nr), 96'd4);
        both_ack = 1'b0;

        // write never acked
        set_tbl(ent(W, 14'h0040, 0, 32'h5), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        wlat = 0;
        run_seq("wack_none", 100, 1'b0);
        chk("wack_none_model", 96'({8'(exp_code), 8'(exp_idx)}), 96'({8'd1, 8'd0}));
        chk("wack_none_timing", 96'(err_cyc - wreq_cyc), 96'(ATO));

        // ack one cycle too late: timeout, late ack ignored
        wlat = ATO;
        run_seq("wack_late", 100, 1'b0);
        chk("wack_late_timing", 96'(err_cyc - wreq_cyc), 96'(ATO));

        // ack on the last allowed cycle
        wlat = ATO - 1;
        run_seq("wack_edge", 100, 1'b0);
        chk("wack_edge_model", 96'(exp_done), 96'd1);

        // table with no END
        set_tbl(ent(W, 14'h0001, 0, 32'h11), ent(W, 14'h0002, 0, 32'h22),
                ent(W, 14'h0003, 0, 32'h33), ent(W, 14'h0004, 0, 32'h44));
        wlat = 1;
        run_seq("overrun", 100, 1'b0);
        chk("overrun_model", 96'({8'(exp_code), 8'(exp_idx), 8'(exp_nw)}), 96'({8'd4, 8'd3, 8'd4}));

        // poll never matches
        set_tbl(ent(P, 14'h0020, 32'hF, 32'h5), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        rlat = 2; rd_script = {};
        run_seq("poll_exhaust", 200, 1'b0);
        chk("poll_exhaust_model", 96'({8'(exp_code), 8'(exp_nr)}), 96'({8'd3, 8'(RETRY)}));

        // read never acked, at index 1
        set_tbl(ent(W, 14'h0010, 0, 32'h1), ent(P, 14'h0011, 32'h1, 32'h1),
                ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        wlat = 1; rlat = 0;
        run_seq("rack_none", 100, 1'b0);
        chk("rack_none_model", 96'({8'(exp_code), 8'(exp_idx)}), 96'({8'd2, 8'd1}));

        // delays of 5 and 0 cycles ahead of a write
        set_tbl(ent(D, 0, 0, 32'd5), ent(W, 14'h0030, 0, 32'h7), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        run_seq("delay5", 100, 1'b0);
        chk("delay5_offset", 96'(wreq_cyc - busy_cyc), 96'd9);
        tbl[0] = ent(D, 0, 0, 32'hFF00_0000);  // only the low 24 bits count
        run_seq("delay0", 100, 1'b0);
        chk("delay0_offset", 96'(wreq_cyc - busy_cyc), 96'd5);

        // reset while waiting for a read ack, then a stray ack
        begin
            int n;
            set_tbl(ent(P, 14'h0017, 32'h1, 32'h1), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
            rlat = 0; rd_script = {};
            build_model();
            nw = 0; nr = 0; w_cd = -1; r_cd = -1; rs_i = 0;
            @(posedge up_clk); #1 start = 1'b1;
            @(posedge up_clk); #1 start = 1'b0;
            n = 0;
            while (nr == 0 && n < 30) begin @(posedge up_clk); #1; n++; end
            chk("rst_reached_read", 96'(nr), 96'd1);
            up_rst = 1'b1;
            @(posedge up_clk); #1;
            check_all_zero("rst_mid_outputs");
            up_rst = 1'b0;
            exp_q.delete();
            inject = 1'b1;
            repeat (20) @(posedge up_clk);
            #1;
            check_all_zero("rst_after_ack_outputs");
            chk("rst_no_more_reqs", 96'({8'(nw), 8'(nr)}), 96'({8'd0, 8'd1}));
        end
        set_tbl(ent(W, 14'h0040, 0, 32'h3), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        wlat = 2;
        run_seq("rst_restart", 100, 1'b0);

        // write with a mask: readback mismatch with verify, mask ignored without
        set_tbl(ent(W, 14'h0041, 32'hFF, 32'hA5), ent(E, 0, 0, 0), ent(E, 0, 0, 0), ent(E, 0, 0, 0));
        wlat = 1; rlat = 1; rd_script = {32'hA4};
        run_seq("masked_write", 100, 1'b0);
`ifdef UP_CFG_SEQ_WRITE_VERIFY_EN
        chk("masked_write_model", 96'({8'(exp_code), 8'(exp_nr)}), 96'({8'd5, 8'd1}));
`else
        chk("masked_write_model", 96'({8'(exp_code), 8'(exp_nr)}), 96'({8'd0, 8'd0}));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
